// File: rtl/ex_alu_muldiv.sv
// Execute-stage ALU with an iterative multiply/divide unit and HI/LO registers.
// Single-cycle operations are purely combinational. MULT/DIV run one bit per
// cycle for WIDTH cycles. mdStall tells the hazard unit to freeze IF/ID/EX
// while a HI/LO instruction waits for the unit to finish.
module ex_alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SA_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [WIDTH-1:0] readRs,
  input  logic [WIDTH-1:0] outMuxEx,
  input  logic [5:0]       instReg,
  input  logic [SA_W-1:0]  sa,
  input  logic [1:0]       ALUOp,
  output logic [WIDTH-1:0] outAlu,
  output logic             zeroAlu,
  output logic             mdStall,
  output logic             mdBusy
);

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  localparam logic [SA_W-1:0] LAST_CNT = SA_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t             state_q, state_d;
  logic [SA_W-1:0]    count_q, count_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;

  logic               is_hilo_funct;
  logic               hilo_req;
  logic               md_accept;
  logic               op_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [SA_W-1:0]    shamt_v;
  logic               lt_signed, lt_unsigned;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Decode HI/LO requests, stall/accept handshakes and signed operand magnitudes.
  always_comb begin
    is_hilo_funct = 1'b0;
    case (instReg)
      F_MFHI, F_MTHI, F_MFLO, F_MTLO,
      F_MULT, F_MULTU, F_DIV, F_DIVU: is_hilo_funct = 1'b1;
      default:                        is_hilo_funct = 1'b0;
    endcase
    mdBusy    = (state_q == S_RUN);
    hilo_req  = valid & (ALUOp == 2'b10) & is_hilo_funct;
    md_accept = hilo_req & ~mdBusy;
    mdStall   = hilo_req & mdBusy;
    op_signed = (instReg == F_MULT) | (instReg == F_DIV);
    a_neg     = op_signed & readRs[WIDTH-1];
    b_neg     = op_signed & outMuxEx[WIDTH-1];
    a_mag     = a_neg ? (~readRs + 1'b1) : readRs;
    b_mag     = b_neg ? (~outMuxEx + 1'b1) : outMuxEx;
  end

  // Single-cycle result mux: ALUOp modes, R-type funct decode and HI/LO reads.
  always_comb begin
    shamt_v     = readRs[SA_W-1:0];
    lt_signed   = $signed(readRs) < $signed(outMuxEx);
    lt_unsigned = readRs < outMuxEx;
    outAlu      = '1;
    case (ALUOp)
      2'b00: outAlu = readRs + outMuxEx;
      2'b01: outAlu = readRs - outMuxEx;
      2'b11: outAlu = outMuxEx;
      default: begin
        case (instReg)
          F_SLL:          outAlu = outMuxEx << sa;
          F_SRL:          outAlu = outMuxEx >> sa;
          F_SRA:          outAlu = $signed(outMuxEx) >>> sa;
          F_SLLV:         outAlu = outMuxEx << shamt_v;
          F_SRLV:         outAlu = outMuxEx >> shamt_v;
          F_SRAV:         outAlu = $signed(outMuxEx) >>> shamt_v;
          F_ADD, F_ADDU:  outAlu = readRs + outMuxEx;
          F_SUB, F_SUBU:  outAlu = readRs - outMuxEx;
          F_AND:          outAlu = readRs & outMuxEx;
          F_OR:           outAlu = readRs | outMuxEx;
          F_XOR:          outAlu = readRs ^ outMuxEx;
          F_NOR:          outAlu = ~(readRs | outMuxEx);
          F_SLT:          outAlu = {{(WIDTH-1){1'b0}}, lt_signed};
          F_SLTU:         outAlu = {{(WIDTH-1){1'b0}}, lt_unsigned};
          F_MFHI:         outAlu = hi_q;
          F_MFLO:         outAlu = lo_q;
          F_MTHI, F_MTLO,
          F_MULT, F_MULTU,
          F_DIV, F_DIVU:  outAlu = '0;
          default:        outAlu = '1;
        endcase
      end
    endcase
    zeroAlu = (outAlu == '0);
  end

  // One iteration of shift-add multiply or restoring divide, plus sign fix-up of the final step.
  always_comb begin
    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_next  = work_q[0] ? {mul_sum, work_q[WIDTH-1:1]}
                          : {1'b0, work_q[2*WIDTH-1:1]};
    div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
    step_next = is_div_q ? div_next : mul_next;
    prod_fix  = neg_lo_q ? (~step_next + 1'b1) : step_next;
    quot_fix  = neg_lo_q ? (~step_next[WIDTH-1:0] + 1'b1) : step_next[WIDTH-1:0];
    rem_fix   = neg_rem_q ? (~step_next[2*WIDTH-1:WIDTH] + 1'b1)
                          : step_next[2*WIDTH-1:WIDTH];
  end

  // Next-state logic: accept HI/LO ops in IDLE, iterate in RUN, write HI/LO on the last step.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    work_d     = work_q;
    opnd_d     = opnd_q;
    dividend_d = dividend_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    case (state_q)
      S_IDLE: begin
        if (md_accept) begin
          case (instReg)
            F_MTHI: hi_d = readRs;
            F_MTLO: lo_d = readRs;
            F_MULT, F_MULTU: begin
              state_d   = S_RUN;
              count_d   = LAST_CNT;
              is_div_d  = 1'b0;
              opnd_d    = a_mag;
              work_d    = {{WIDTH{1'b0}}, b_mag};
              neg_lo_d  = a_neg ^ b_neg;
              neg_rem_d = 1'b0;
              dz_d      = 1'b0;
            end
            F_DIV, F_DIVU: begin
              state_d    = S_RUN;
              count_d    = LAST_CNT;
              is_div_d   = 1'b1;
              opnd_d     = b_mag;
              work_d     = {{WIDTH{1'b0}}, a_mag};
              neg_lo_d   = a_neg ^ b_neg;
              neg_rem_d  = a_neg;
              dz_d       = (outMuxEx == '0);
              dividend_d = readRs;
            end
            default: ;
          endcase
        end
      end
      default: begin
        work_d  = step_next;
        count_d = count_q - 1'b1;
        if (count_q == '0) begin
          state_d = S_IDLE;
          if (!is_div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (dz_q) begin
            hi_d = dividend_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end
      end
    endcase
  end

  // State registers; reset aborts any operation in flight and clears HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      work_q     <= '0;
      opnd_q     <= '0;
      dividend_q <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      work_q     <= work_d;
      opnd_q     <= opnd_d;
      dividend_q <= dividend_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
    end
  end

endmodule

// File: tb/tb_ex_alu_muldiv.sv
// Randomized self-checking bench for ex_alu_muldiv against an arithmetic reference model.
module tb_ex_alu_muldiv;

   localparam int WIDTH = 32;

   localparam logic [5:0] F_SRA   = 6'b000011;
   localparam logic [5:0] F_SRLV  = 6'b000110;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SLTU  = 6'b101011;

   logic             clk;
   logic             reset;
   logic             valid;
   logic [WIDTH-1:0] readRs;
   logic [WIDTH-1:0] outMuxEx;
   logic [5:0]       instReg;
   logic [4:0]       sa;
   logic [1:0]       ALUOp;
   logic [WIDTH-1:0] outAlu;
   logic             zeroAlu;
   logic             mdStall;
   logic             mdBusy;

   int               vectorsApplied;
   int               miscompares;
   logic [31:0]      modelHi;
   logic [31:0]      modelLo;

   logic [5:0] aluFuncts [20] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100,
                                  6'b000110, 6'b000111, 6'b100000, 6'b100001,
                                  6'b100010, 6'b100011, 6'b100100, 6'b100101,
                                  6'b100110, 6'b100111, 6'b101010, 6'b101011,
                                  6'b010000, 6'b010010, 6'b111111, 6'b001000};

   ex_alu_muldiv #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .valid    (valid),
      .readRs   (readRs),
      .outMuxEx (outMuxEx),
      .instReg  (instReg),
      .sa       (sa),
      .ALUOp    (ALUOp),
      .outAlu   (outAlu),
      .zeroAlu  (zeroAlu),
      .mdStall  (mdStall),
      .mdBusy   (mdBusy)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if the observed value differs.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
      vectorsApplied++;
      if (got !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, expected);
      end
   endtask

   // Drive one set of EX-stage inputs and let combinational outputs settle.
   task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [5:0] f,
                                input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
      valid    = v;
      ALUOp    = op;
      instReg  = f;
      readRs   = a;
      outMuxEx = b;
      sa       = s;
      #1;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference result for one single-cycle instruction, from the instruction-set meaning.
   function automatic logic [31:0] expAlu(input logic [1:0] op, input logic [5:0] f,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] s, input logic [31:0] hi,
                                          input logic [31:0] lo);
      int sb;
      sb = int'(b);
      case (op)
         2'b00: return a + b;
         2'b01: return a - b;
         2'b11: return b;
         default: ;
      endcase
      case (f)
         6'b000000: return b << s;
         6'b000010: return b >> s;
         6'b000011: return 32'(sb >>> s);
         6'b000100: return b << a[4:0];
         6'b000110: return b >> a[4:0];
         6'b000111: return 32'(sb >>> a[4:0]);
         6'b100000, 6'b100001: return a + b;
         6'b100010, 6'b100011: return a - b;
         6'b100100: return a & b;
         6'b100101: return a | b;
         6'b100110: return a ^ b;
         6'b100111: return ~(a | b);
         6'b101010: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         6'b101011: return (a < b) ? 32'd1 : 32'd0;
         F_MFHI: return hi;
         F_MFLO: return lo;
         F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: return 32'd0;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   // Reference HI/LO after a multiply or divide, using native 64-bit and signed arithmetic.
   task automatic mdModel(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
      logic [63:0] p;
      longint      sp;
      hi = 32'd0;
      lo = 32'd0;
      case (f)
         F_MULT: begin
            sp = longint'(int'(a)) * longint'(int'(b));
            p  = 64'(sp);
            hi = p[63:32];
            lo = p[31:0];
         end
         F_MULTU: begin
            p  = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
         end
         default: begin
            if (b == 32'd0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else if (f == F_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000;
               hi = 32'd0;
            end else if (f == F_DIV) begin
               lo = 32'(int'(a) / int'(b));
               hi = 32'(int'(a) % int'(b));
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
      endcase
   endtask

   // Operand mix weighted toward small, negative and corner values.
   function automatic logic [31:0] randOperand();
      case ($urandom_range(0, 3))
         0: return 32'($urandom);
         1: return 32'($urandom_range(0, 20));
         2: return 32'd0 - 32'($urandom_range(1, 20));
         default: begin
            case ($urandom_range(0, 3))
               0: return 32'd0;
               1: return 32'h8000_0000;
               2: return 32'hFFFF_FFFF;
               default: return 32'h7FFF_FFFF;
            endcase
         end
      endcase
   endfunction

   // Issue one MULT/DIV, check busy for its whole duration, then read HI and LO back.
   task automatic runMulDiv(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eh, el;
      applyStimulus(1'b1, 2'b10, f, a, b, 5'($urandom));
      checkOutput("startStall", {31'd0, mdStall}, 32'd0);
      checkOutput("startOut", outAlu, 32'd0);
      tick();
      mdModel(f, a, b, eh, el);
      for (int i = 0; i < WIDTH; i++) begin
         applyStimulus(1'b0, 2'($urandom), 6'($urandom), 32'($urandom), 32'($urandom), 5'($urandom));
         checkOutput("busyDuring", {31'd0, mdBusy}, 32'd1);
         tick();
      end
      checkOutput("busyDone", {31'd0, mdBusy}, 32'd0);
      modelHi = eh;
      modelLo = el;
      applyStimulus(1'b1, 2'b10, F_MFHI, 32'($urandom), 32'($urandom), 5'd0);
      checkOutput("readHi", outAlu, modelHi);
      tick();
      applyStimulus(1'b1, 2'b10, F_MFLO, 32'($urandom), 32'($urandom), 5'd0);
      checkOutput("readLo", outAlu, modelLo);
      tick();
   endtask

   logic [5:0]  rf;
   logic [1:0]  rop;
   logic [31:0] ra, rb, ex;
   logic [4:0]  rs;
   logic [5:0]  mdFuncts [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};

   // Main stimulus sequence.
   initial begin
      vectorsApplied = 0;
      miscompares    = 0;
      modelHi        = 32'd0;
      modelLo        = 32'd0;
      reset          = 1'b1;
      applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 5'd0);
      tick();
      tick();
      reset = 1'b0;

      // Reset state.
      checkOutput("resetBusy", {31'd0, mdBusy}, 32'd0);
      applyStimulus(1'b1, 2'b10, F_MFHI, 32'd7, 32'd9, 5'd0);
      checkOutput("resetHi", outAlu, 32'd0);
      checkOutput("resetHiZero", {31'd0, zeroAlu}, 32'd1);
      applyStimulus(1'b1, 2'b10, F_MFLO, 32'd7, 32'd9, 5'd0);
      checkOutput("resetLo", outAlu, 32'd0);
      tick();

      // Directed single-cycle cases.
      applyStimulus(1'b1, 2'b10, F_SRA, 32'd0, 32'h8000_0000, 5'd4);
      checkOutput("sra", outAlu, 32'hF800_0000);
      applyStimulus(1'b1, 2'b10, F_SRLV, 32'h24, 32'hF0, 5'd0);
      checkOutput("srlv", outAlu, 32'h0F);
      applyStimulus(1'b1, 2'b10, F_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0);
      checkOutput("sltu", outAlu, 32'd0);
      checkOutput("sltuZero", {31'd0, zeroAlu}, 32'd1);
      applyStimulus(1'b1, 2'b10, 6'b111110, 32'd3, 32'd3, 5'd0);
      checkOutput("undef", outAlu, 32'hFFFF_FFFF);
      checkOutput("undefZero", {31'd0, zeroAlu}, 32'd0);
      tick();

      // Random single-cycle instructions.
      for (int i = 0; i < 300; i++) begin
         rop = 2'($urandom);
         rf  = aluFuncts[$urandom_range(0, 19)];
         ra  = randOperand();
         rb  = randOperand();
         rs  = 5'($urandom);
         applyStimulus(1'b1, rop, rf, ra, rb, rs);
         ex = expAlu(rop, rf, ra, rb, rs, modelHi, modelLo);
         checkOutput("aluRand", outAlu, ex);
         checkOutput("zeroRand", {31'd0, zeroAlu}, {31'd0, ex == 32'd0});
         checkOutput("noStall", {31'd0, mdStall}, 32'd0);
         tick();
      end

      // Directed multiply/divide cases.
      runMulDiv(F_MULT, 32'hFFFF_FFFD, 32'd5);
      runMulDiv(F_DIVU, 32'd100, 32'd7);
      runMulDiv(F_DIV, 32'hFFFF_FFF9, 32'd2);
      runMulDiv(F_DIVU, 32'd5, 32'd0);
      runMulDiv(F_DIV, 32'hFFFF_FFF9, 32'd0);
      runMulDiv(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      runMulDiv(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // Random multiply/divide operations.
      for (int i = 0; i < 24; i++) begin
         runMulDiv(mdFuncts[$urandom_range(0, 3)], randOperand(), randOperand());
      end

      // MULT immediately followed by MFLO: stall for the whole operation.
      applyStimulus(1'b1, 2'b10, F_MULT, 32'd1234, 32'hFFFF_FF00, 5'd0);
      tick();
      mdModel(F_MULT, 32'd1234, 32'hFFFF_FF00, modelHi, modelLo);
      for (int i = 1; i <= WIDTH; i++) begin
         applyStimulus(1'b1, 2'b10, F_MFLO, 32'($urandom), 32'($urandom), 5'd0);
         checkOutput("mfloStall", {31'd0, mdStall}, 32'd1);
         tick();
      end
      applyStimulus(1'b1, 2'b10, F_MFLO, 32'($urandom), 32'($urandom), 5'd0);
      checkOutput("mfloRelease", {31'd0, mdStall}, 32'd0);
      checkOutput("mfloValue", outAlu, modelLo);
      tick();

      // Non-HI/LO work proceeds while the unit is busy.
      applyStimulus(1'b1, 2'b10, F_MULTU, 32'd6, 32'd7, 5'd0);
      tick();
      applyStimulus(1'b1, 2'b10, F_ADDU, 32'd2, 32'd3, 5'd0);
      checkOutput("adduBusy", outAlu, 32'd5);
      checkOutput("adduNoStall", {31'd0, mdStall}, 32'd0);
      checkOutput("adduUnitBusy", {31'd0, mdBusy}, 32'd1);
      tick();
      for (int i = 2; i <= WIDTH; i++) begin
         applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 5'd0);
         tick();
      end
      mdModel(F_MULTU, 32'd6, 32'd7, modelHi, modelLo);
      applyStimulus(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0, 5'd0);
      checkOutput("adduThenLo", outAlu, 32'd42);
      tick();

      // MTLO/MTHI then read back in the next cycle.
      applyStimulus(1'b1, 2'b10, F_MTLO, 32'h1234, 32'd0, 5'd0);
      checkOutput("mtloOut", outAlu, 32'd0);
      tick();
      modelLo = 32'h1234;
      applyStimulus(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0, 5'd0);
      checkOutput("mtloRead", outAlu, 32'h1234);
      tick();
      applyStimulus(1'b1, 2'b10, F_MTHI, 32'hCAFE_0001, 32'd0, 5'd0);
      tick();
      modelHi = 32'hCAFE_0001;
      applyStimulus(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0, 5'd0);
      checkOutput("mthiRead", outAlu, 32'hCAFE_0001);
      tick();

      // Bubbles never start, write or stall.
      applyStimulus(1'b0, 2'b10, F_MULT, 32'd3, 32'd3, 5'd0);
      checkOutput("bubbleStall", {31'd0, mdStall}, 32'd0);
      tick();
      checkOutput("bubbleBusy", {31'd0, mdBusy}, 32'd0);
      applyStimulus(1'b0, 2'b10, F_MTLO, 32'hDEAD_BEEF, 32'd0, 5'd0);
      tick();
      applyStimulus(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0, 5'd0);
      checkOutput("bubbleNoWrite", outAlu, modelLo);
      tick();

      // Reset in cycle 10 of a MULT aborts it and clears HI/LO.
      applyStimulus(1'b1, 2'b10, F_MULT, 32'hFFFF_FFFD, 32'd5, 5'd0);
      tick();
      for (int i = 1; i < 10; i++) begin
         applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 5'd0);
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      modelHi = 32'd0;
      modelLo = 32'd0;
      checkOutput("abortBusy", {31'd0, mdBusy}, 32'd0);
      applyStimulus(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0, 5'd0);
      checkOutput("abortHi", outAlu, 32'd0);
      checkOutput("abortStall", {31'd0, mdStall}, 32'd0);
      tick();
      applyStimulus(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0, 5'd0);
      checkOutput("abortLo", outAlu, 32'd0);
      tick();
      for (int i = 0; i < WIDTH; i++) begin
         applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 5'd0);
         tick();
      end
      applyStimulus(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0, 5'd0);
      checkOutput("abortNoLateWrite", outAlu, 32'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
